// File: rtl/qpsk_pkg.sv
`default_nettype none
// qpsk_pkg: shared constants, output word type and decision helper for the QPSK RX packer.
// Rev 1.0
package qpsk_pkg;

  // Nominal TX amplitudes for a 1 bit and a 0 bit.
  localparam logic [15:0] ONE  = 16'h6665;
  localparam logic [15:0] ZERO = 16'h999B;

  localparam int SYMS_PER_WORD = 16;
  localparam int BITS_PER_SYM  = 2;
  localparam int WORD_W        = SYMS_PER_WORD * BITS_PER_SYM;
  localparam int CNT_W         = 4;
  localparam int NSYM_W        = 5;

  localparam int I_MSB = 31;
  localparam int I_LSB = 16;
  localparam int Q_MSB = 15;
  localparam int Q_LSB = 0;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic              last;
    logic [NSYM_W-1:0] nsym;
  } word_t;

  // Non-negative (including exact zero) decides 1 before optional inversion.
  function automatic logic decide(input logic sign, input logic invert);
    return ~sign ^ invert;
  endfunction

endpackage
`default_nettype wire

// File: rtl/qpsk_slicer.sv
`default_nettype none
// qpsk_slicer: combinational hard decision of one {I,Q} sample into a {bI,bQ} bit pair.
// Rev 1.0
module qpsk_slicer
  import qpsk_pkg::*;
#(
  parameter logic INVERT_I = 1'b0,
  parameter logic INVERT_Q = 1'b0
) (
  input  logic [31:0] i_sample,
  output logic [1:0]  o_bits
);

  // Only the sign bits matter; magnitudes are deliberately dropped.
  logic w_unused_mag;
  assign w_unused_mag = ^{i_sample[I_MSB-1:I_LSB], i_sample[Q_MSB-1:Q_LSB]};

  assign o_bits = {decide(i_sample[I_MSB], INVERT_I),
                   decide(i_sample[Q_MSB], INVERT_Q)};

endmodule
`default_nettype wire

// File: rtl/qpsk_symbol_packer.sv
`default_nettype none
// qpsk_symbol_packer: sign-slices {I,Q} samples and packs 16 symbols MSB-first per 32-bit word.
// Rev 1.0
module qpsk_symbol_packer
  import qpsk_pkg::*;
#(
  parameter logic INVERT_I = 1'b0,
  parameter logic INVERT_Q = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       in_tdata,
  input  logic              in_tlast,
  input  logic              in_tvalid,
  output logic              in_tready,
  output logic [31:0]       out_tdata,
  output logic              out_tlast,
  output logic [NSYM_W-1:0] out_nsym,
  output logic              out_tvalid,
  input  logic              out_tready
);

  logic [1:0]        w_bits;
  logic              w_last_sym;
  logic              w_accept;
  logic              w_complete;
  logic [WORD_W-1:0] w_sr_next;

  logic [CNT_W-1:0]  r_cnt;
  logic [WORD_W-1:0] r_sr;
  word_t             r_out;
  logic              r_out_valid;

  qpsk_slicer #(
    .INVERT_I (INVERT_I),
    .INVERT_Q (INVERT_Q)
  ) u_slicer (
    .i_sample (in_tdata),
    .o_bits   (w_bits)
  );

  assign w_last_sym = (r_cnt == CNT_W'(SYMS_PER_WORD - 1)) || in_tlast;

  // Only a completing beat needs the output register, so only it can stall.
  assign in_tready  = !(r_out_valid && !out_tready && w_last_sym);
  assign w_accept   = in_tvalid && in_tready;
  assign w_complete = w_accept && w_last_sym;

  // Symbols are placed left-aligned so a short word needs no final shift.
  assign w_sr_next = r_sr | ({w_bits, {(WORD_W - BITS_PER_SYM){1'b0}}} >> {r_cnt, 1'b0});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_sr  <= '0;
    end else if (w_accept) begin
      if (w_complete) begin
        r_cnt <= '0;
        r_sr  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
        r_sr  <= w_sr_next;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else if (w_complete) begin
      r_out.data  <= w_sr_next;
      r_out.last  <= in_tlast;
      r_out.nsym  <= NSYM_W'(r_cnt) + 5'd1;
      r_out_valid <= 1'b1;
    end else if (out_tready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_tdata  = r_out.data;
  assign out_tlast  = r_out.last;
  assign out_nsym   = r_out.nsym;
  assign out_tvalid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_qpsk_symbol_packer.sv
`default_nettype none
// tb_qpsk_symbol_packer: directed self-checking bench for qpsk_symbol_packer.
// Rev 1.0
module tb_qpsk_symbol_packer;
  import qpsk_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_tdata;
  logic        in_tlast;
  logic        in_tvalid;
  logic        in_tready;
  logic [31:0] out_tdata;
  logic        out_tlast;
  logic [4:0]  out_nsym;
  logic        out_tvalid;
  logic        out_tready;

  logic        inv_in_tready;
  logic [31:0] inv_out_tdata;
  logic        inv_out_tlast;
  logic [4:0]  inv_out_nsym;
  logic        inv_out_tvalid;

  int n_checks = 0;
  int n_errors = 0;
  int n_stall  = 0;

  always #5 clk = ~clk;

  qpsk_symbol_packer dut (
    .clk        (clk),
    .reset      (reset),
    .in_tdata   (in_tdata),
    .in_tlast   (in_tlast),
    .in_tvalid  (in_tvalid),
    .in_tready  (in_tready),
    .out_tdata  (out_tdata),
    .out_tlast  (out_tlast),
    .out_nsym   (out_nsym),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready)
  );

  qpsk_symbol_packer #(
    .INVERT_I (1'b1),
    .INVERT_Q (1'b0)
  ) dut_inv (
    .clk        (clk),
    .reset      (reset),
    .in_tdata   (in_tdata),
    .in_tlast   (in_tlast),
    .in_tvalid  (in_tvalid),
    .in_tready  (inv_in_tready),
    .out_tdata  (inv_out_tdata),
    .out_tlast  (inv_out_tlast),
    .out_nsym   (inv_out_nsym),
    .out_tvalid (inv_out_tvalid),
    .out_tready (out_tready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic send_beat(input logic [31:0] d, input logic last);
    int n;
    n = 0;
    in_tdata  = d;
    in_tlast  = last;
    in_tvalid = 1'b1;
    #1;
    while (!in_tready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    n_stall += n;
    if (n >= 200) begin
      chk("rdy_timeout", 32'd0, 32'd1);
      @(negedge clk);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
  endtask

  task automatic send_rep(input logic [31:0] d, input int n, input logic last_at_end);
    for (int i = 0; i < n; i++) send_beat(d, last_at_end && (i == n - 1));
  endtask

  // Emulates the TX converter: each bit pair of w becomes one {I,Q} sample.
  task automatic send_word(input logic [31:0] w);
    logic [1:0]  pair;
    logic [31:0] s;
    for (int k = 0; k < 16; k++) begin
      pair = w[31 - 2*k -: 2];
      s    = {pair[1] ? ONE : ZERO, pair[0] ? ONE : ZERO};
      if (k == 15) chk("early_valid", {31'd0, out_tvalid}, 32'd0);
      send_beat(s, 1'b0);
    end
    chk("rt_valid", {31'd0, out_tvalid}, 32'd1);
    chk("rt_data", out_tdata, w);
  endtask

  task automatic chk_word(input string tag, input logic [31:0] d, input logic [4:0] ns, input logic lst);
    chk({tag, "_valid"}, {31'd0, out_tvalid}, 32'd1);
    chk({tag, "_data"},  out_tdata, d);
    chk({tag, "_nsym"},  {27'd0, out_nsym}, {27'd0, ns});
    chk({tag, "_last"},  {31'd0, out_tlast}, {31'd0, lst});
  endtask

  task automatic chk_full16(input string tag, input logic [31:0] sample, input logic [31:0] d);
    send_rep(sample, 15, 1'b0);
    chk({tag, "_pre"}, {31'd0, out_tvalid}, 32'd0);
    send_rep(sample, 1, 1'b0);
    chk_word(tag, d, 5'd16, 1'b0);
  endtask

  initial begin
    reset      = 1'b1;
    in_tdata   = '0;
    in_tlast   = 1'b0;
    in_tvalid  = 1'b0;
    out_tready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_data",  out_tdata, 32'd0);
    chk("rst_nsym",  {27'd0, out_nsym}, 32'd0);
    chk("rst_last",  {31'd0, out_tlast}, 32'd0);
    chk("rst_valid", {31'd0, out_tvalid}, 32'd0);
    chk("rst_ready", {31'd0, in_tready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk_full16("ones", 32'h66656665, 32'hFFFFFFFF);
    @(negedge clk);
    chk("ones_clear", {31'd0, out_tvalid}, 32'd0);
    chk_full16("alt_a", 32'h6665999B, 32'hAAAAAAAA);
    chk_full16("alt_5", 32'h999B6665, 32'h55555555);
    chk_full16("zero",  32'h00000000, 32'hFFFFFFFF);

    // Partial packet, then a full word to confirm the counter restarted.
    send_rep(32'h66656665, 3, 1'b1);
    chk_word("part", 32'hFC000000, 5'd3, 1'b1);
    chk("inv_part_data", inv_out_tdata, 32'h54000000);
    chk("inv_part_nsym", {27'd0, inv_out_nsym}, 32'd3);
    chk_full16("restart", 32'h6665999B, 32'hAAAAAAAA);

    // Exact 16-symbol packet: single completion with tlast, no trailing empty word.
    send_rep(32'h6665999B, 16, 1'b1);
    chk_word("exact16", 32'hAAAAAAAA, 5'd16, 1'b1);
    @(negedge clk);
    chk("exact16_noextra", {31'd0, out_tvalid}, 32'd0);

    // Backpressure.
    out_tready = 1'b0;
    n_stall    = 0;
    send_rep(32'h66656665, 16, 1'b0);
    chk_word("bp_first", 32'hFFFFFFFF, 5'd16, 1'b0);
    send_rep(32'h999B999B, 15, 1'b0);
    chk("bp_nostall", n_stall, 32'd0);
    in_tdata  = 32'h999B999B;
    in_tlast  = 1'b0;
    in_tvalid = 1'b1;
    #1;
    chk("bp_rdy_low", {31'd0, in_tready}, 32'd0);
    repeat (2) @(negedge clk);
    #1;
    chk("bp_hold_data",  out_tdata, 32'hFFFFFFFF);
    chk("bp_hold_valid", {31'd0, out_tvalid}, 32'd1);
    chk("bp_rdy_still",  {31'd0, in_tready}, 32'd0);
    in_tlast = 1'b1;
    #1;
    chk("bp_tlast_rdy", {31'd0, in_tready}, 32'd0);
    in_tlast   = 1'b0;
    out_tready = 1'b1;
    #1;
    chk("bp_rdy_high", {31'd0, in_tready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_tvalid = 1'b0;
    chk_word("bp_second", 32'h00000000, 5'd16, 1'b0);
    @(negedge clk);
    chk("bp_clear", {31'd0, out_tvalid}, 32'd0);

    // Continuous streaming: 4 words back-to-back, including the round-trip value.
    n_stall = 0;
    send_word(32'h1234ABCD);
    send_word(32'hDEADBEEF);
    send_word(32'h0F0F3C96);
    send_word(32'h80000001);
    chk("stream_nostall", n_stall, 32'd0);
    @(negedge clk);

    // Reset mid-word discards the partial word.
    send_rep(32'h66656665, 7, 1'b0);
    reset = 1'b1;
    #1;
    chk("mrst_data",  out_tdata, 32'd0);
    chk("mrst_nsym",  {27'd0, out_nsym}, 32'd0);
    chk("mrst_last",  {31'd0, out_tlast}, 32'd0);
    chk("mrst_valid", {31'd0, out_tvalid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_full16("after_rst", 32'h999B6665, 32'h55555555);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/qpsk_symbol_packer.md
Name: qpsk_symbol_packer

Overview:
- Receive-side counterpart of the QPSK bit-to-symbol converter in the RFNoC QPSK chain.
- Accepts a stream of 32-bit {I,Q} baseband samples, one QPSK symbol per beat.
- Hard-decides each component by sign and packs 16 symbols, MSB-first, into a 32-bit data word on an AXI-Stream style output.
- Sits after the RX demod/timing-recovery block, ahead of the RFNoC output port.

Parameters:
- INVERT_I, 0, when 1 the I decision bit is inverted (constellation flip).
- INVERT_Q, 0, when 1 the Q decision bit is inverted.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- in_tdata  in  32  sample; [31:16] = I, [15:0] = Q, both two's complement
- in_tlast  in  1  last sample of packet; flushes a partial word
- in_tvalid  in  1  input valid
- in_tready  out  1  input ready
- out_tdata  out  32  packed bits; first symbol in [31:30]
- out_tlast  out  1  word terminates a packet
- out_nsym  out  5  number of valid symbols in word, 1..16
- out_tvalid  out  1  output valid
- out_tready  in  1  downstream ready

Behaviour:
- Reset values: out_tdata=0, out_tlast=0, out_nsym=0, out_tvalid=0. Symbol counter cnt=0, shift register sr=0.
- Decision rule: bI = ~I[15] ^ INVERT_I; bQ = ~Q[15] ^ INVERT_Q.
  - A value >= 0 decides 1.
  - Exact zero decides 1.
  - Amplitudes 0x6665 and 0x999B therefore map to 1 and 0 respectively.
- Symbol k of a word (k = 0..15) lands in bits [31-2k] = bI and [30-2k] = bQ. This inverts the TX converter's bit-pair-to-{I,Q} mapping.
- Beat accepted when in_tvalid && in_tready:
  - Shift {bI,bQ} into sr.
  - cnt increments.
- Word complete when an accepted beat has cnt==15 or in_tlast=1. On that clock edge:
  - out_tdata <= left-aligned word; unused low bits are 0.
  - out_nsym <= cnt+1.
  - out_tlast <= in_tlast.
  - out_tvalid <= 1.
  - cnt <= 0 and sr <= 0.
- Latency: one clock from the completing input beat to out_tvalid.
- Output register holds all of its fields stable while out_tvalid && !out_tready.
- out_tvalid clears on out_tready unless a new word completes on the same edge. In that case the new word loads and out_tvalid stays 1, giving full throughput.
- in_tready = !(out_tvalid && !out_tready && (cnt==15 || in_tlast)).
  - The input stalls only when the beat would complete a word while the output register is still occupied.
  - Non-completing beats keep flowing, so 15 symbols can accumulate under backpressure.
  - in_tready depends combinationally on in_tlast, out_tvalid and out_tready. It does not depend on in_tvalid.
- No state machine beyond cnt plus the output-valid flag. States are ACCUM (cnt 0..15) crossed with out_tvalid (EMPTY/FULL).
- Packet of exactly 16k symbols: the last word has nsym=16 and tlast=1. No extra empty word is emitted.
- in_tlast with cnt==15 is handled as a single completion with tlast=1.
- Reset mid-word: the partial word is discarded and not emitted.
- out_tdata changes only on load. It is never updated while the output is held.

Decomposition:
- Shared package qpsk_pkg holds:
  - ONE=16'h6665, ZERO=16'h999B
  - SYMS_PER_WORD=16
  - BITS_PER_SYM=2
  - sample field positions I=[31:16], Q=[15:0]
- Natural sub-module: qpsk_slicer, a combinational sign decision with invert parameters producing {bI,bQ}.
- Packer, counter and output register stay in the top.

Test Plan:
- 16 beats of 0x66656665, out_tready=1 -> one word 0xFFFFFFFF, nsym=16, tlast=0, valid one cycle after beat 16.
- 16 beats of 0x6665999B -> 0xAAAAAAAA.
- 16 beats of 0x999B6665 -> 0x55555555.
- 16 beats of 0x00000000 -> 0xFFFFFFFF (zero decides 1).
- Round-trip: feed TX converter output for input 0x1234ABCD -> 0x1234ABCD.
- 3 beats of 0x66656665 with tlast on the 3rd -> 0xFC000000, nsym=3, tlast=1; next word restarts at cnt=0.
- Partial case with INVERT_I=1 -> 0x54000000.
- Backpressure:
  - Hold out_tready=0 after the first word 0xFFFFFFFF.
  - Send 15 more beats of 0x999B999B -> all accepted; in_tready drops on the 16th while out_tdata stays 0xFFFFFFFF.
  - Raise out_tready -> 16th beat accepted same cycle, next word 0x00000000.
- Continuous streaming: 64 beats, out_tready=1 -> 4 back-to-back words, in_tready never low.
- Assert reset after 7 beats -> all outputs 0; the next 16 beats produce exactly one correct word.
